mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the multicycle MIPS datapath. It sits downstream of the A/B operand registers and upstream of the register-bank write-data mux.
- Implements MULT, MULTU, DIV and DIVU into architectural HI/LO registers, and supports direct HI/LO writes for MTHI/MTLO.
- The control unit starts an operation with a pulse and holds its multicycle FSM until done.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, 32, iterations per operation; must equal WIDTH.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  begin operation; sampled only in IDLE
- op  in  2  md_op_t: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3
- a_in  in  WIDTH  operand A (multiplicand / dividend), from A register
- b_in  in  WIDTH  operand B (multiplier / divisor), from B register
- hi_we  in  1  direct HI write (MTHI)
- lo_we  in  1  direct LO write (MTLO)
- wdata  in  WIDTH  data for hi_we/lo_we
- busy  out  1  operation in progress (state != IDLE)
- done  out  1  one-cycle pulse; HI/LO valid in the same cycle
- div_by_zero  out  1  sticky flag for the last DIV/DIVU with b_in==0; cleared by the next accepted start
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Clock and reset: one clock, `clock`; reset is synchronous and active-high on `reset`. Reset forces state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, and clears all internal registers. Reset mid-operation aborts with no done pulse.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE, start=1, divide op with b_in==0:
  - go directly to DONE and set div_by_zero=1.
  - hi/lo stay unchanged; done pulses in the next cycle.
- IDLE, start=1, all other cases:
  - Latch |a|, |b| as unsigned magnitudes; for signed ops, take the two's-complement magnitude if the MSB is set.
  - Latch sign_q = a[31]^b[31] and sign_r = a[31], clear the iteration count, clear div_by_zero, go to RUN.
- RUN, multiply: one shift-add step per cycle on a 64-bit accumulator {acc_hi, acc_lo}.
  - If multiplier LSB=1, add |a| into acc_hi with carry; then shift {carry, acc} right by 1.
- RUN, divide: one restoring step per cycle.
  - Shift {rem, quo} left by 1 and trial-subtract |b| from rem.
  - If no borrow: keep the difference and set quo LSB=1; otherwise restore.
- RUN exit: after ITER cycles (count == ITER-1), go to FIX.
- FIX:
  - Signed ops: product = sign_q ? -acc : acc (64-bit); quotient = sign_q ? -quo : quo; remainder = sign_r ? -rem : rem.
  - Write hi/lo: multiply gives hi=product[63:32], lo=product[31:0]; divide gives hi=remainder, lo=quotient.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- Latency: start sampled at edge E0 → done high in the cycle after E33 (33 cycles), for all ops. Divide-by-zero: done high in the cycle after E0.
- Overflow: DIV of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- start while busy: ignored; operands are not re-latched.
- Direct writes:
  - hi_we/lo_we act only in IDLE with start=0; both may be asserted together (same wdata).
  - In IDLE with start=1 the writes are dropped.
  - While busy the writes are ignored.
- hi/lo hold their value between completions and are never visible mid-update.

Decomposition:
- mips_pkg holds:
  - typedef enum logic [1:0] md_op_t {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  - typedef enum logic [1:0] md_state_t {MD_IDLE, MD_RUN, MD_FIX, MD_DONE};
  - localparam MD_ITER = 32.
- One sub-module is natural: md_iter_core, the magnitude shift-add/restoring datapath with an op-select step enable. The FSM, sign handling and HI/LO registers stay in mult_div_unit.

Test Plan:
- MULT, a=0xFFFFFFFE, b=0x00000003, one-cycle start → busy high 34 cycles; done 33 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU, a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, div_by_zero=0.
- DIV, a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV, a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Preload hi=0x11111111 via hi_we, then DIVU with b=0 → done the next cycle, div_by_zero=1, hi=0x11111111 unchanged. A following MULTU 2×3 clears div_by_zero: hi=0, lo=6.
- Start MULT 5×7, pulse start with op=DIV at cycle 5 and assert lo_we at cycle 6 → both ignored; exactly one done, lo=35, hi=0.
- Start DIVU, assert reset at cycle 10 → next cycle busy=0, hi=lo=0; no done pulse. A new MULTU 4×4 then gives lo=16.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared types and constants for the multicycle MIPS datapath
// Revision : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

   typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_t;
   typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_FIX, MD_DONE} md_state_t;

   localparam int MD_ITER = 32;

   function automatic logic md_is_div(input md_op_t op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic md_is_signed(input md_op_t op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

`default_nettype wire

// File: rtl/md_iter_core.sv
// ============================================================================
// md_iter_core : unsigned shift-add multiply / restoring divide datapath
// Revision     : 1.0
// ============================================================================
`default_nettype none

module md_iter_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic             i_step,
   input  logic             i_is_div,
   input  logic [WIDTH-1:0] i_a_mag,
   input  logic [WIDTH-1:0] i_b_mag,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   // Multiply: r_hi:r_lo is the accumulator, r_lo starts as the multiplier.
   // Divide:   r_hi is the remainder, r_lo starts as dividend and ends as quotient.
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_m;
   logic             r_is_div;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH-1:0] w_diff;
   logic             w_borrow;

   always_comb begin
      w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
      w_shift  = {r_hi, r_lo[WIDTH-1]};
      w_borrow = (w_shift < {1'b0, r_m});
      w_diff   = w_shift[WIDTH-1:0] - r_m;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi     <= '0;
         r_lo     <= '0;
         r_m      <= '0;
         r_is_div <= 1'b0;
      end else if (i_load) begin
         r_hi     <= '0;
         r_is_div <= i_is_div;
         if (i_is_div) begin
            r_lo <= i_a_mag;
            r_m  <= i_b_mag;
         end else begin
            r_lo <= i_b_mag;
            r_m  <= i_a_mag;
         end
      end else if (i_step) begin
         if (r_is_div) begin
            r_hi <= w_borrow ? w_shift[WIDTH-1:0] : w_diff;
            r_lo <= {r_lo[WIDTH-2:0], ~w_borrow};
         end else begin
            r_hi <= w_sum[WIDTH:1];
            r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
         end
      end
   end

   assign o_hi = r_hi;
   assign o_lo = r_lo;

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// mult_div_unit : iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Revision      : 1.0
// ============================================================================
`default_nettype none

module mult_div_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITER  = MD_ITER
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  md_op_t           op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int c_CNT_W = $clog2(ITER);
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(ITER - 1);

   md_state_t          r_state;
   md_op_t             r_op;
   logic               r_sign_q;
   logic               r_sign_r;
   logic [c_CNT_W-1:0] r_count;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_busy;
   logic               r_done;
   logic               r_dbz;

   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic               w_start_dbz;
   logic               w_load;
   logic [WIDTH-1:0]   w_core_hi;
   logic [WIDTH-1:0]   w_core_lo;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   always_comb begin
      w_a_neg     = md_is_signed(op) & a_in[WIDTH-1];
      w_b_neg     = md_is_signed(op) & b_in[WIDTH-1];
      w_a_mag     = w_a_neg ? -a_in : a_in;
      w_b_mag     = w_b_neg ? -b_in : b_in;
      w_start_dbz = md_is_div(op) && (b_in == '0);
      w_load      = (r_state == MD_IDLE) && start && !w_start_dbz;
      // Sign flags are only ever set for signed ops, so no op check is needed here.
      w_prod      = r_sign_q ? -{w_core_hi, w_core_lo} : {w_core_hi, w_core_lo};
      w_quo       = r_sign_q ? -w_core_lo : w_core_lo;
      w_rem       = r_sign_r ? -w_core_hi : w_core_hi;
   end

   md_iter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk      (clock),
      .rst      (reset),
      .i_load   (w_load),
      .i_step   (r_state == MD_RUN),
      .i_is_div (md_is_div(op)),
      .i_a_mag  (w_a_mag),
      .i_b_mag  (w_b_mag),
      .o_hi     (w_core_hi),
      .o_lo     (w_core_lo)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= MD_IDLE;
         r_op     <= MD_MULT;
         r_sign_q <= 1'b0;
         r_sign_r <= 1'b0;
         r_count  <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_dbz    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            MD_IDLE: begin
               if (start) begin
                  r_op   <= op;
                  r_busy <= 1'b1;
                  r_dbz  <= w_start_dbz;
                  if (w_start_dbz) begin
                     r_state <= MD_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_sign_q <= w_a_neg ^ w_b_neg;
                     r_sign_r <= w_a_neg;
                     r_count  <= '0;
                     r_state  <= MD_RUN;
                  end
               end else begin
                  if (hi_we) r_hi <= wdata;
                  if (lo_we) r_lo <= wdata;
               end
            end
            MD_RUN: begin
               r_count <= r_count + 1'b1;
               if (r_count == c_LAST) r_state <= MD_FIX;
            end
            MD_FIX: begin
               if (md_is_div(r_op)) begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end else begin
                  r_hi <= w_prod[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod[WIDTH-1:0];
               end
               r_done  <= 1'b1;
               r_state <= MD_DONE;
            end
            MD_DONE: begin
               r_busy  <= 1'b0;
               r_state <= MD_IDLE;
            end
            default: r_state <= MD_IDLE;
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign div_by_zero = r_dbz;
   assign hi          = r_hi;
   assign lo          = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// tb_mult_div_unit : directed + random checks of mult_div_unit against a model
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_mult_div_unit;
   import mips_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   md_op_t      op    = MD_MULT;
   logic [31:0] a_in  = '0;
   logic [31:0] b_in  = '0;
   logic        hi_we = 1'b0;
   logic        lo_we = 1'b0;
   logic [31:0] wdata = '0;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_hi  = '0;
   logic [31:0] m_lo  = '0;
   logic        m_dbz = 1'b0;

   mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .a_in        (a_in),
      .b_in        (b_in),
      .hi_we       (hi_we),
      .lo_we       (lo_we),
      .wdata       (wdata),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Architectural reference: plain 64-bit arithmetic on the operands.
   task automatic model_op(input md_op_t o, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      m_dbz = 1'b0;
      case (o)
         MD_MULT: begin
            p = 64'(sa * sb);
            m_hi = p[63:32];
            m_lo = p[31:0];
         end
         MD_MULTU: begin
            p = {32'b0, a} * {32'b0, b};
            m_hi = p[63:32];
            m_lo = p[31:0];
         end
         MD_DIV: begin
            if (b == 0) m_dbz = 1'b1;
            else begin
               q = sa / sb;
               r = sa % sb;
               m_lo = q[31:0];
               m_hi = r[31:0];
            end
         end
         default: begin
            if (b == 0) m_dbz = 1'b1;
            else begin
               m_lo = a / b;
               m_hi = a % b;
            end
         end
      endcase
   endtask

   task automatic run_op(input md_op_t o, input logic [31:0] a, input logic [31:0] b);
      int n;
      int busy_n;
      int exp_lat;
      exp_lat = ((o == MD_DIV || o == MD_DIVU) && b == 0) ? 0 : 33;
      model_op(o, a, b);
      @(negedge clock);
      start = 1'b1;
      op    = o;
      a_in  = a;
      b_in  = b;
      @(posedge clock); #1;
      start  = 1'b0;
      n      = 0;
      busy_n = busy ? 1 : 0;
      while (!done && n < 60) begin
         @(posedge clock); #1;
         n++;
         if (busy) busy_n++;
      end
      check("latency", 64'(n), 64'(exp_lat));
      check("hi", {32'b0, hi}, {32'b0, m_hi});
      check("lo", {32'b0, lo}, {32'b0, m_lo});
      check("div_by_zero", {63'b0, div_by_zero}, {63'b0, m_dbz});
      @(posedge clock); #1;
      if (busy) busy_n++;
      check("done_pulse_width", {63'b0, done}, 64'd0);
      check("busy_cycles", 64'(busy_n), 64'(exp_lat + 1));
   endtask

   task automatic write_hilo(input logic h, input logic l, input logic [31:0] d);
      @(negedge clock);
      hi_we = h;
      lo_we = l;
      wdata = d;
      @(posedge clock); #1;
      hi_we = 1'b0;
      lo_we = 1'b0;
      if (h) m_hi = d;
      if (l) m_lo = d;
      check("mt_hi", {32'b0, hi}, {32'b0, m_hi});
      check("mt_lo", {32'b0, lo}, {32'b0, m_lo});
   endtask

   initial begin
      int dones;
      logic [31:0] ra, rb;
      md_op_t ro;

      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      check("reset_hi", {32'b0, hi}, 64'd0);
      check("reset_lo", {32'b0, lo}, 64'd0);
      check("reset_busy", {63'b0, busy}, 64'd0);
      check("reset_done", {63'b0, done}, 64'd0);
      check("reset_dbz", {63'b0, div_by_zero}, 64'd0);

      run_op(MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003);
      run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
      run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
      write_hilo(1'b1, 1'b0, 32'h1111_1111);
      run_op(MD_DIVU,  32'h0000_1234, 32'h0000_0000);
      run_op(MD_MULTU, 32'h0000_0002, 32'h0000_0003);

      // start and lo_we while busy must both be ignored
      model_op(MD_MULT, 32'd5, 32'd7);
      @(negedge clock);
      start = 1'b1; op = MD_MULT; a_in = 32'd5; b_in = 32'd7;
      @(posedge clock); #1;
      start = 1'b0;
      dones = 0;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clock);
         start = (c == 5);
         if (c == 5) begin op = MD_DIV; b_in = 32'd0; end
         lo_we = (c == 6);
         wdata = 32'hDEAD_BEEF;
         @(posedge clock); #1;
         if (done) dones++;
      end
      start = 1'b0; lo_we = 1'b0;
      check("busy_start_dones", 64'(dones), 64'd1);
      check("busy_start_lo", {32'b0, lo}, {32'b0, m_lo});
      check("busy_start_hi", {32'b0, hi}, {32'b0, m_hi});
      check("busy_start_dbz", {63'b0, div_by_zero}, 64'd0);

      // reset mid-operation aborts silently
      @(negedge clock);
      start = 1'b1; op = MD_DIVU; a_in = 32'd1000; b_in = 32'd7;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (9) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      m_hi = '0; m_lo = '0; m_dbz = 1'b0;
      check("abort_busy", {63'b0, busy}, 64'd0);
      check("abort_hi", {32'b0, hi}, 64'd0);
      check("abort_lo", {32'b0, lo}, 64'd0);
      dones = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clock); #1;
         if (done) dones++;
      end
      check("abort_no_done", 64'(dones), 64'd0);
      run_op(MD_MULTU, 32'd4, 32'd4);

      for (int i = 0; i < 24; i++) begin
         ro = md_op_t'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = $urandom_range(1, 5);
            2: ra = 32'h8000_0000;
            3: rb = 32'hFFFF_FFFF;
            default: ;
         endcase
         if ($urandom_range(0, 3) == 0)
            write_hilo(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
         run_op(ro, ra, rb);
      end

      write_hilo(1'b1, 1'b1, 32'hA5A5_5A5A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
